// File: rtl/gf4_mask_pkg.sv
// Shared constants and state type for the GF(2^4) mask-refresh slice.
// Four Boolean shares of a nibble, refreshed with 12 bits of randomness.
package gf4_mask_pkg;

   localparam int NSHARES    = 4;
   localparam int GF4_W      = 4;
   localparam int RND_W      = 12;
   localparam int SHARE_W    = NSHARES * GF4_W;
   localparam int WARMUP_DEF = 16;

   typedef enum logic {
      WARMUP,
      RUN
   } state_e;

endpackage

// File: rtl/gf4_share_fifo2.sv
// Two-entry FIFO holding packed refreshed shares.
// Read data comes straight from the storage registers.
module gf4_share_fifo2
   import gf4_mask_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_i,
   input  logic [SHARE_W-1:0] wdata_i,
   input  logic               pop_i,
   output logic [SHARE_W-1:0] rdata_o,
   output logic [1:0]         occ_o
);

   logic [SHARE_W-1:0] mem_q [2];
   logic               wptr_q;
   logic               rptr_q;
   logic [1:0]         occ_q;
   logic [1:0]         occ_d;
   logic               do_push;
   logic               do_pop;

   assign do_push = push_i && (occ_q != 2'd2);
   assign do_pop  = pop_i && (occ_q != 2'd0);

   always_comb begin
      occ_d = occ_q;
      unique case ({do_push, do_pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   // 1-bit pointers wrap 1->0 on their own
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         occ_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (do_pop) rptr_q <= rptr_q + 1'b1;
         occ_q <= occ_d;
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign occ_o   = occ_q;

endmodule

// File: rtl/gf4_mask_refresh.sv
// Re-masks a 4-share GF(2^4) operand with fresh randomness, after a
// PRNG warm-up, and buffers results in a 2-entry FIFO.
module gf4_mask_refresh
   import gf4_mask_pkg::*;
#(
   parameter int WARMUP_CYCLES = WARMUP_DEF,
   parameter bit REFRESH_EN    = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [GF4_W-1:0] in_1,
   input  logic [GF4_W-1:0] in_2,
   input  logic [GF4_W-1:0] in_3,
   input  logic [GF4_W-1:0] in_4,
   input  logic             rnd_valid,
   output logic             rnd_ready,
   input  logic [RND_W-1:0] rnd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [GF4_W-1:0] out_1,
   output logic [GF4_W-1:0] out_2,
   output logic [GF4_W-1:0] out_3,
   output logic [GF4_W-1:0] out_4,
   output logic [7:0]       beat_cnt
);

   localparam int WCW = $clog2(WARMUP_CYCLES + 1);

   state_e             state_q, state_d;
   logic [WCW-1:0]     wcnt_q, wcnt_d;
   logic [7:0]         bcnt_q, bcnt_d;
   logic [1:0]         occ;
   logic               accept;
   logic               pop;
   logic [RND_W-1:0]   rm;
   logic [GF4_W-1:0]   r0, r1, r2;
   logic [SHARE_W-1:0] wdata;
   logic [SHARE_W-1:0] rdata;

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      in_ready  = 1'b0;
      rnd_ready = 1'b0;
      unique case (state_q)
         WARMUP: begin
            // Reset also gates the combinational PRNG handshake
            rnd_ready = rst_n;
            if (rnd_valid) begin
               wcnt_d = wcnt_q + WCW'(1);
               if (wcnt_q == WCW'(WARMUP_CYCLES - 1)) state_d = RUN;
            end
         end
         RUN: begin
            in_ready  = rnd_valid && (occ != 2'd2);
            rnd_ready = in_valid && in_ready;
         end
         default: ;
      endcase
   end

   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;
   assign bcnt_d = bcnt_q + 8'(pop);

   assign rm = REFRESH_EN ? rnd : '0;
   assign r0 = rm[3:0];
   assign r1 = rm[7:4];
   assign r2 = rm[11:8];

   // Each share only mixes with its own mask terms
   assign wdata = {in_1 ^ r0,
                   in_2 ^ r1,
                   in_3 ^ r2,
                   in_4 ^ r0 ^ r1 ^ r2};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WARMUP;
         wcnt_q  <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         bcnt_q  <= bcnt_d;
      end
   end

   gf4_share_fifo2 u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (accept),
      .wdata_i (wdata),
      .pop_i   (pop),
      .rdata_o (rdata),
      .occ_o   (occ)
   );

   assign out_valid = (occ != 2'd0);
   assign {out_1, out_2, out_3, out_4} = rdata;
   assign beat_cnt = bcnt_q;

endmodule

// File: tb/tb_gf4_mask_refresh.sv
// Scoreboard bench for gf4_mask_refresh: directed vectors with
// hand-computed refreshed shares, checked by a separate monitor.
module tb_gf4_mask_refresh;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid, in_ready;
   logic [3:0] in_1, in_2, in_3, in_4;
   logic       rnd_valid, rnd_ready;
   logic [11:0] rnd;
   logic       out_valid, out_ready;
   logic [3:0] out_1, out_2, out_3, out_4;
   logic [7:0] beat_cnt;

   gf4_mask_refresh dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_1      (in_1),
      .in_2      (in_2),
      .in_3      (in_3),
      .in_4      (in_4),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready),
      .rnd       (rnd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_1     (out_1),
      .out_2     (out_2),
      .out_3     (out_3),
      .out_4     (out_4),
      .beat_cnt  (beat_cnt)
   );

   always #5 clk = ~clk;

   // {in_1,in_2,in_3,in_4}, rnd, and hand-computed {out_1..out_4}
   localparam logic [15:0] VIN [8] = '{16'hA350, 16'h1234, 16'hFFFF,
      16'h0000, 16'h5678, 16'hC003, 16'h9186, 16'h7701};
   localparam logic [11:0] VRN [8] = '{12'h124, 12'h000, 12'hFFF,
      12'h321, 12'h9AB, 12'h0F0, 12'h555, 12'h800};
   localparam logic [15:0] VEX [8] = '{16'hE147, 16'h1234, 16'h0000,
      16'h1230, 16'hECE0, 16'hCF0C, 16'hC4D3, 16'h7789};

   typedef struct packed {
      logic [15:0] sh;
      logic [3:0]  x;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   pops = 0;
   int   pop_base = 0;

   function automatic logic [3:0] xor4(input logic [15:0] v);
      return v[15:12] ^ v[11:8] ^ v[7:4] ^ v[3:0];
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("shares", {out_1, out_2, out_3, out_4}, e.sh);
               check("share_xor", xor4({out_1, out_2, out_3, out_4}), e.x);
            end
            pops++;
         end
      end
   end

   task automatic drive(input int i);
      {in_1, in_2, in_3, in_4} = VIN[i];
      rnd = VRN[i];
   endtask

   task automatic send(input int i);
      logic ok;
      ok = 1'b0;
      drive(i);
      in_valid  = 1'b1;
      rnd_valid = 1'b1;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         if (in_ready) begin
            check("rnd_ready_on_accept", rnd_ready, 1);
            exp_q.push_back({VEX[i], xor4(VIN[i])});
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check("accept_timeout", ok, 1);
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
   endtask

   task automatic wait_drain();
      logic done;
      done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) done = 1'b1;
      end
      if (!done) check("drain_timeout", done, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic warmup();
      rnd_valid = 1'b1;
      repeat (16) @(posedge clk);
      #1;
      rnd_valid = 1'b0;
   endtask

   initial begin
      logic seen;
      drive(0);
      in_valid  = 1'b1;
      rnd_valid = 1'b1;
      out_ready = 1'b1;

      // Reset values with both upstream valids high
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_rnd_ready", rnd_ready, 0);
      check("rst_outs", {out_1, out_2, out_3, out_4}, 0);
      check("rst_beat_cnt", beat_cnt, 0);

      // Warm-up: 16 cycles stalled, accept in cycle 17
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         check("warmup_in_ready", in_ready, 0);
      end
      @(negedge clk);
      check("run_in_ready", in_ready, 1);
      check("run_rnd_ready", rnd_ready, 1);
      exp_q.push_back({VEX[0], xor4(VIN[0])});
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
      @(negedge clk);
      check("latency_out_valid", out_valid, 1);
      check("refresh_xor_c", xor4({out_1, out_2, out_3, out_4}), 4'hC);
      wait_drain();
      check("beat_cnt_first", beat_cnt, 1);

      // Backpressure: two accepted, third refused while full
      rst_n = 1'b0;
      #1;
      check("reset_beat_cnt", beat_cnt, 0);
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      pop_base = pops;
      warmup();
      out_ready = 1'b0;
      send(1);
      send(2);
      drive(3);
      in_valid  = 1'b1;
      rnd_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("full_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      check("full_with_out_ready", in_ready, 0);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
      wait_drain();
      check("beat_cnt_backpressure", beat_cnt, 2);

      // Push and pop together at occupancy 1
      out_ready = 1'b0;
      send(4);
      out_ready = 1'b1;
      send(5);
      out_ready = 1'b0;
      rnd_valid = 1'b1;
      @(negedge clk);
      check("occ1_out_valid", out_valid, 1);
      check("occ1_in_ready", in_ready, 1);
      check("occ1_head", {out_1, out_2, out_3, out_4}, VEX[5]);
      @(posedge clk);
      #1;
      rnd_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      // Stream to 300 pops since reset; beat_cnt wraps to 44
      for (int k = 0; k < 296; k++) send(k % 8);
      wait_drain();
      check("pop_total", pops - pop_base, 300);
      check("beat_cnt_wrap", beat_cnt, 44);

      // rnd_valid low stalls input but not draining
      out_ready = 1'b0;
      send(6);
      drive(7);
      in_valid  = 1'b1;
      rnd_valid = 1'b0;
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_rnd_ready", rnd_ready, 0);
      check("stall_out_valid", out_valid, 1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      check("stall_in_ready_drain", in_ready, 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("stall_drained", out_valid, 0);
      check("beat_cnt_stall", beat_cnt, 45);

      // Reset with two beats buffered
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(7);
      send(1);
      drive(3);
      in_valid  = 1'b1;
      rnd_valid = 1'b1;
      @(negedge clk);
      check("full_before_reset", in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_rnd_ready", rnd_ready, 0);
      check("midrst_outs", {out_1, out_2, out_3, out_4}, 0);
      check("midrst_beat_cnt", beat_cnt, 0);
      exp_q.delete();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      pop_base = pops;
      seen = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (c == 0) check("warmup_after_rst", rnd_ready, 1);
         seen = seen | out_valid;
      end
      check("no_stale_beat", seen, 0);
      send(2);
      wait_drain();
      check("beat_cnt_after_rst", beat_cnt, 1);
      check("pops_after_rst", pops - pop_base, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gf4_mask_refresh.md
GF4_MASK_REFRESH -- requirements
Module: gf4_mask_refresh

Interface
REQ-001 The block SHALL have parameter WARMUP_CYCLES, default 16: number of randomness beats discarded after reset before data is accepted.
REQ-002 The block SHALL have parameter REFRESH_EN, default 1: 1 = apply fresh masks, 0 = pass shares unchanged (debug only).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream holds a valid 4-share GF(2^4) value.
REQ-006 in_ready  output  1  block accepts the input this cycle.
REQ-007 in_1, in_2, in_3, in_4  input  4 each  Boolean shares of the operand.
REQ-008 rnd_valid  input  1  PRNG word available.
REQ-009 rnd_ready  output  1  block consumes the PRNG word this cycle.
REQ-010 rnd  input  12  fresh randomness; r0=rnd[3:0], r1=rnd[7:4], r2=rnd[11:8].
REQ-011 out_valid  output  1  refreshed shares are valid.
REQ-012 out_ready  input  1  downstream (the masked GF(2^4) inverter stage) accepts.
REQ-013 out_1, out_2, out_3, out_4  output  4 each  refreshed shares, driven directly from registers.
REQ-014 beat_cnt  output  8  count of output beats delivered.

Function
REQ-015 States SHALL be WARMUP and RUN; reset enters WARMUP.
REQ-016 In WARMUP: rnd_ready=1, in_ready=0; each rnd beat (rnd_valid=1) increments a warm-up counter.
REQ-017 On the WARMUP_CYCLES-th rnd beat the state SHALL become RUN at that clock edge; RUN is held until reset.
REQ-018 In RUN: in_ready = rnd_valid AND occupancy<2; rnd_ready = in_valid AND in_ready. Randomness is consumed only with an accepted input.
REQ-019 Accept = in_valid AND in_ready. On accept the block SHALL push out_1=in_1^r0, out_2=in_2^r1, out_3=in_3^r2, out_4=in_4^r0^r1^r2 into a 2-entry FIFO. With REFRESH_EN=0 all r terms are treated as 0.
REQ-020 The XOR of the four output shares SHALL always equal the XOR of the accepted input shares.
REQ-021 Each output share SHALL depend only on its own input share and randomness; no cross-share combinational logic.
REQ-022 Latency: a beat accepted at edge k SHALL appear with out_valid=1 in the cycle after edge k if the FIFO was empty.
REQ-023 out_valid = occupancy!=0. Pop = out_valid AND out_ready. Outputs are held stable while out_valid=1 and out_ready=0.
REQ-024 Push and pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-025 Full (occupancy 2): in_ready=0, regardless of out_ready in that cycle.
REQ-026 Read and write pointers SHALL be 1 bit and wrap 1->0.
REQ-027 beat_cnt SHALL increment on each pop and wrap 255->0.
REQ-028 rnd_valid=0 in RUN SHALL stall input (in_ready=0) without affecting draining of the FIFO.

Reset
REQ-029 rst_n=0 SHALL immediately clear: state=WARMUP, warm-up counter=0, FIFO storage and pointers=0, occupancy=0, beat_cnt=0.
REQ-030 Output values during reset: out_valid=0, in_ready=0, rnd_ready=0, out_1..out_4=0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered beats; no beat is emitted after release until a new accept in RUN.

Structure
REQ-032 Package gf4_mask_pkg SHALL hold NSHARES=4, GF4_W=4, RND_W=12, the state enum (WARMUP, RUN), and the WARMUP_CYCLES default.
REQ-033 The FIFO SHALL be the sub-module gf4_share_fifo2: 2 entries of 16 bits, with push/pop/occupancy ports.
REQ-034 Mask-refresh XOR logic SHALL live in the top level, registered directly into FIFO storage.

Verification
REQ-035 Warm-up: reset released, rnd_valid=1 and in_valid=1 held -> in_ready=0 for exactly 16 cycles, in_ready=1 in cycle 17.
REQ-036 Refresh: in_1..4=A,3,5,0; rnd=12'h124 -> out_1..4=E,1,4,7 one cycle later; XOR of outputs = C.
REQ-037 Backpressure: out_ready=0, 3 beats offered -> 2 accepted, then in_ready=0; release out_ready -> beats emitted in order, beat_cnt=2.
REQ-038 Simultaneous push and pop at occupancy 1 -> occupancy stays 1, order preserved; 300 pops -> beat_cnt=44.
REQ-039 rnd_valid=0 in RUN with one beat buffered -> in_ready=0, rnd_ready=0, buffered beat still drains.
REQ-040 rst_n pulsed low with 2 beats buffered -> out_valid=0 immediately, state WARMUP, no stale beat emitted after release.
